// File: rtl/excess3_bcd_arbiter.sv
// Two-requester excess-3 to BCD converter with burst-limited round-robin grant.
// Define EXCESS3_ERR_COUNT_EN to add the saturating illegal-code counter output err_count.
module excess3_bcd_arbiter #(
  parameter int BURST = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0_valid,
  input  logic [3:0] in0_e,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [3:0] in1_e,
  output logic       in1_ready,
  output logic       out_valid,
  output logic [3:0] out_b,
  output logic       out_src,
  output logic       out_err,
  input  logic       out_ready
`ifdef EXCESS3_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  logic [1:0] state_reg, state_next;
  logic [3:0] burst_reg, burst_next;
  logic       out_valid_reg;
  logic [3:0] out_b_reg;
  logic       out_src_reg;
  logic       out_err_reg;

  logic       slot_free;
  logic       grant_valid;
  logic       grant;
  logic       accept;
  logic [3:0] sel_e;
  logic       sel_legal;
  logic [3:0] conv_b;

  always_comb begin
    slot_free   = !out_valid_reg || out_ready;
    grant_valid = 1'b0;
    grant       = 1'b0;
    case (state_reg)
      SERVE0: begin
        if (in0_valid && (!in1_valid || burst_reg < 4'(BURST))) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (in1_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
      end
      SERVE1: begin
        if (in1_valid && (!in0_valid || burst_reg < 4'(BURST))) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end else if (in0_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end
      end
      default: begin
        if (in0_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (in1_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
      end
    endcase
    // Gating with rst_n keeps both readies low throughout reset.
    accept    = rst_n && slot_free && grant_valid;
    in0_ready = accept && !grant;
    in1_ready = accept && grant;

    sel_e     = grant ? in1_e : in0_e;
    sel_legal = (sel_e >= 4'd3) && (sel_e <= 4'd12);
    conv_b    = sel_legal ? (sel_e - 4'd3) : 4'd0;
  end

  always_comb begin
    state_next = state_reg;
    burst_next = burst_reg;
    if (accept) begin
      if ((state_reg == SERVE0 && !grant) || (state_reg == SERVE1 && grant)) begin
        burst_next = (burst_reg == 4'd15) ? 4'd15 : burst_reg + 4'd1;
      end else begin
        state_next = grant ? SERVE1 : SERVE0;
        burst_next = 4'd1;
      end
    end else if (slot_free && !in0_valid && !in1_valid) begin
      state_next = IDLE;
      burst_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      burst_reg     <= 4'd0;
      out_valid_reg <= 1'b0;
      out_b_reg     <= 4'd0;
      out_src_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      burst_reg <= burst_next;
      // A new accept overwrites the slot on the same edge it is consumed.
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_b_reg     <= conv_b;
        out_src_reg   <= grant;
        out_err_reg   <= !sel_legal;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef EXCESS3_ERR_COUNT_EN
  logic [7:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_reg <= 8'd0;
    end else if (accept && !sel_legal && err_count_reg != 8'd255) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_b     = out_b_reg;
  assign out_src   = out_src_reg;
  assign out_err   = out_err_reg;

endmodule
